// File: rtl/mul_pkg.sv
// Shared types and constants for the two-requester shift-add multiplier scheduler.
// No logic; imported by mul_sched.
// Backpressure: not applicable.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_t;

  localparam int N_DEF   = 8;
  localparam int NUM_REQ = 2;

endpackage

// File: rtl/rca_add.sv
// Purpose: W-bit ripple-carry adder.
// Latency: combinational.
// Backpressure: none.
module rca_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/mul_sched.sv
// Purpose: round-robin scheduler sharing one shift-add multiplier between two requesters.
// Latency: resp_valid rises N/2 edges after the request handshake edge.
// Backpressure: result held in RESP until resp_ready; no new request accepted until then.
module mul_sched
  import mul_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [N/2-1:0]     req_a0,
  input  logic [N/2-1:0]     req_b0,
  input  logic [N/2-1:0]     req_a1,
  input  logic [N/2-1:0]     req_b1,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [N-1:0]       resp_y
);

  localparam int H   = N / 2;
  localparam int CTW = $clog2(H);

  state_t         state, state_nxt;
  logic [H-1:0]   a_q, b_q;
  logic           id_q;
  logic           lp;
  logic [N-1:0]   acc;
  logic [N-1:0]   term;
  logic [N-1:0]   sum;
  logic [CTW-1:0] ct;
  logic           g;
  logic           req_hs;
  logic           resp_hs;
  logic           last_step;

  // Both pending: serve the one not served last; otherwise whichever is pending.
  assign g = (&req_valid) ? ~lp : req_valid[1];

  assign term      = {{(N-H){1'b0}}, b_q & {H{a_q[ct]}}} << ct;
  assign last_step = (ct == CTW'(H - 1));

  rca_add #(.W(N)) u_add (
    .a   (acc),
    .b   (term),
    .cin (1'b0),
    .sum (sum),
    .cout()
  );

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    req_hs     = 1'b0;
    resp_valid = 1'b0;
    resp_y     = '0;
    resp_id    = 1'b0;
    resp_hs    = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gating keeps req_ready low during the very first reset cycle.
        if (rst_n && (|req_valid)) begin
          req_ready[g] = 1'b1;
          req_hs       = 1'b1;
          state_nxt    = ACC;
        end
      end
      ACC: begin
        if (last_step) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_y     = acc;
        resp_id    = id_q;
        if (resp_ready) begin
          resp_hs   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
      lp   <= 1'b1;
      acc  <= '0;
      ct   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            a_q  <= g ? req_a1 : req_a0;
            b_q  <= g ? req_b1 : req_b0;
            id_q <= g;
            acc  <= '0;
            ct   <= '0;
          end
        end
        ACC: begin
          acc <= sum;
          ct  <= last_step ? '0 : ct + CTW'(1);
        end
        RESP: begin
          if (resp_hs) lp <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule
